mac_dot_seq: RTL and testbench

MAC_DOT_SEQ -- requirements
Module: mac_dot_seq

---
 rtl/mac_seq_pkg.sv | 14 +
 rtl/mac_dot_seq.sv | 117 +++++++++++
 tb/tb_mac_dot_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_pkg.sv
// Shared definitions for the sequential FP32 dot-product controller.
package mac_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;

endpackage

// File: rtl/mac_dot_seq.sv
// Sequences K multiply-accumulate steps through an external FP32 FMA stage,
// one in flight at a time, with a watchdog on each FMA round trip.
module mac_dot_seq
  import mac_seq_pkg::*;
#(
  parameter int unsigned KW  = 8,
  parameter int unsigned TMO = 15
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [KW-1:0] k_i,
  input  logic [31:0]   init_acc_i,
  output logic          busy_o,
  input  logic          op_valid_i,
  output logic          op_ready_o,
  input  logic [31:0]   data_in_i,
  input  logic [31:0]   weight_in_i,
  output logic          mac_valid_o,
  output logic [31:0]   mac_data_o,
  output logic [31:0]   mac_weight_o,
  output logic [31:0]   mac_acc_o,
  input  logic          mac_finished_i,
  input  logic [31:0]   mac_acc_i,
  output logic          res_valid_o,
  input  logic          res_ready_i,
  output logic [31:0]   res_o,
  output logic          err_o
);

  localparam int unsigned TW = (TMO > 1) ? $clog2(TMO + 1) : 1;

  state_t        state, state_d;
  logic [KW-1:0] k_q;
  logic [KW-1:0] cnt;
  logic [KW-1:0] cnt_inc;
  logic [31:0]   acc_q;
  logic          err;
  logic [TW-1:0] wcnt;
  logic          tmo_hit;

  assign cnt_inc = cnt + KW'(1);
  // A returning result on the last allowed cycle wins over the timeout.
  assign tmo_hit = (state == WAIT) && !mac_finished_i && (wcnt == TW'(TMO - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (start_i) state_d = (k_i == '0) ? DONE : ISSUE;
      ISSUE: if (op_valid_i) state_d = WAIT;
      WAIT: begin
        if (mac_finished_i)  state_d = (cnt_inc == k_q) ? DONE : ISSUE;
        else if (tmo_hit)    state_d = DONE;
      end
      DONE:  if (res_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      k_q          <= '0;
      cnt          <= '0;
      acc_q        <= FP32_ZERO;
      err          <= 1'b0;
      wcnt         <= '0;
      mac_valid_o  <= 1'b0;
      mac_data_o   <= '0;
      mac_weight_o <= '0;
      mac_acc_o    <= '0;
    end else begin
      mac_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            k_q   <= k_i;
            acc_q <= init_acc_i;
            cnt   <= '0;
            err   <= 1'b0;
          end
        end
        ISSUE: begin
          if (op_valid_i) begin
            mac_data_o   <= data_in_i;
            mac_weight_o <= weight_in_i;
            mac_acc_o    <= acc_q;
            mac_valid_o  <= 1'b1;
            wcnt         <= '0;
          end
        end
        WAIT: begin
          if (mac_finished_i) begin
            acc_q <= mac_acc_i;
            cnt   <= cnt_inc;
          end else if (tmo_hit) begin
            err <= 1'b1;
          end else begin
            wcnt <= wcnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o      = (state != IDLE);
  assign op_ready_o  = (state == ISSUE);
  assign res_valid_o = (state == DONE);
  assign res_o       = acc_q;
  assign err_o       = err;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Scoreboard bench for mac_dot_seq: directed dot products against a table-driven FMA model.
module tb_mac_dot_seq;
  import mac_seq_pkg::*;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic [7:0]  k_i;
  logic [31:0] init_acc_i;
  logic        busy_o;
  logic        op_valid_i;
  logic        op_ready_o;
  logic [31:0] data_in_i;
  logic [31:0] weight_in_i;
  logic        mac_valid_o;
  logic [31:0] mac_data_o;
  logic [31:0] mac_weight_o;
  logic [31:0] mac_acc_o;
  logic        mac_finished_i;
  logic [31:0] mac_acc_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [31:0] res_o;
  logic        err_o;

  mac_dot_seq #(.KW(8), .TMO(15)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .k_i            (k_i),
    .init_acc_i     (init_acc_i),
    .busy_o         (busy_o),
    .op_valid_i     (op_valid_i),
    .op_ready_o     (op_ready_o),
    .data_in_i      (data_in_i),
    .weight_in_i    (weight_in_i),
    .mac_valid_o    (mac_valid_o),
    .mac_data_o     (mac_data_o),
    .mac_weight_o   (mac_weight_o),
    .mac_acc_o      (mac_acc_o),
    .mac_finished_i (mac_finished_i),
    .mac_acc_i      (mac_acc_i),
    .res_valid_o    (res_valid_o),
    .res_ready_i    (res_ready_i),
    .res_o          (res_o),
    .err_o          (err_o)
  );

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    logic [31:0] w;
    logic [31:0] a;
    logic [31:0] r;
  } fma_t;

  exp_t sb[$];
  fma_t fma_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int mv_cnt = 0;
  bit fma_en = 1'b1;
  int fma_delay = 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mac_valid_o) mv_cnt <= mv_cnt + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0:       return op_ready_o;
      1:       return res_valid_o;
      2:       return mac_valid_o;
      3:       return !busy_o;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (probe(sel)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: timed out after %0d cycles", name, budget);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},       32'(busy_o),      32'h0);
    chk({tag, "_op_ready"},   32'(op_ready_o),  32'h0);
    chk({tag, "_mac_valid"},  32'(mac_valid_o), 32'h0);
    chk({tag, "_res_valid"},  32'(res_valid_o), 32'h0);
    chk({tag, "_err"},        32'(err_o),       32'h0);
    chk({tag, "_mac_data"},   mac_data_o,       32'h0);
    chk({tag, "_mac_weight"}, mac_weight_o,     32'h0);
    chk({tag, "_mac_acc"},    mac_acc_o,        32'h0);
    chk({tag, "_res"},        res_o,            32'h0);
  endtask

  // lat < 0 means no result is expected (aborted by reset)
  task automatic do_start(input logic [7:0] k, input logic [31:0] init, input int lat,
                          input logic [31:0] eres, input logic eerr);
    @(posedge clk); #1;
    start_i    = 1'b1;
    k_i        = k;
    init_acc_i = init;
    if (lat >= 0) sb.push_back('{res: eres, err: eerr, cyc: cyc + lat});
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic feed_pair(input logic [31:0] d, input logic [31:0] w);
    op_valid_i  = 1'b1;
    data_in_i   = d;
    weight_in_i = w;
    wait_for(0, 50, "op_ready");
    @(posedge clk); #1;
  endtask

  task automatic feed_pair_gap(input logic [31:0] d, input logic [31:0] w);
    op_valid_i = 1'b0;
    wait_for(0, 50, "op_ready_gap");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("op_ready_held", 32'(op_ready_o), 32'h1);
    end
    @(posedge clk); #1;
    op_valid_i  = 1'b1;
    data_in_i   = d;
    weight_in_i = w;
    @(posedge clk); #1;
    op_valid_i = 1'b0;
  endtask

  // FMA stand-in: checks the issued operands against the table, returns the hand-computed sum
  initial begin
    fma_t e;
    mac_finished_i = 1'b0;
    mac_acc_i      = '0;
    forever begin
      @(negedge clk);
      if (mac_valid_o && fma_en) begin
        if (fma_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL fma_unexpected_issue: got issue expected none");
        end else begin
          e = fma_q.pop_front();
          chk("fma_data",   mac_data_o,   e.d);
          chk("fma_weight", mac_weight_o, e.w);
          chk("fma_acc",    mac_acc_o,    e.a);
          repeat (fma_delay) @(posedge clk);
          #1;
          mac_finished_i = 1'b1;
          mac_acc_i      = e.r;
          @(posedge clk); #1;
          mac_finished_i = 1'b0;
        end
      end
    end
  end

  // Monitor: pop on each new result, then hold-check while it is presented
  initial begin
    exp_t cur;
    bit   prev = 1'b0;
    bit   have = 1'b0;
    forever begin
      @(negedge clk);
      if (res_valid_o) begin
        if (!prev) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            have = 1'b0;
            $display("FAIL res_unexpected: got res %h expected no result", res_o);
          end else begin
            cur  = sb.pop_front();
            have = 1'b1;
            chk("res_value",   res_o,        cur.res);
            chk("res_err",     32'(err_o),   32'(cur.err));
            chk("res_latency", 32'(cyc),     32'(cur.cyc));
          end
        end else if (have) begin
          chk("res_hold",     res_o,      cur.res);
          chk("res_err_hold", 32'(err_o), 32'(cur.err));
        end
      end
      prev = res_valid_o;
    end
  end

  initial begin
    int mv0;
    rst_i       = 1'b1;
    start_i     = 1'b0;
    k_i         = '0;
    init_acc_i  = '0;
    op_valid_i  = 1'b0;
    data_in_i   = '0;
    weight_in_i = '0;
    res_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // 0 + 1*2 + 3*4 + 0.5*0.5 = 14.25, op_valid held high
    fma_q.push_back('{d: FP32_ONE,     w: 32'h4000_0000, a: FP32_ZERO,     r: 32'h4000_0000});
    fma_q.push_back('{d: 32'h4040_0000, w: 32'h4080_0000, a: 32'h4000_0000, r: 32'h4160_0000});
    fma_q.push_back('{d: 32'h3F00_0000, w: 32'h3F00_0000, a: 32'h4160_0000, r: 32'h4164_0000});
    mv0 = mv_cnt;
    do_start(8'd3, FP32_ZERO, 10, 32'h4164_0000, 1'b0);
    feed_pair(FP32_ONE, 32'h4000_0000);
    feed_pair(32'h4040_0000, 32'h4080_0000);
    feed_pair(32'h3F00_0000, 32'h3F00_0000);
    op_valid_i = 1'b0;
    wait_for(3, 40, "idle_t1");
    chk("t1_mac_pulses",  32'(mv_cnt - mv0), 32'd3);
    chk("t1_data_hold",   mac_data_o,   32'h3F00_0000);
    chk("t1_weight_hold", mac_weight_o, 32'h3F00_0000);
    chk("t1_acc_hold",    mac_acc_o,    32'h4160_0000);

    // K = 0 returns the initial accumulator after one cycle
    mv0 = mv_cnt;
    do_start(8'd0, 32'h4049_0FDB, 1, 32'h4049_0FDB, 1'b0);
    wait_for(3, 10, "idle_t2");
    chk("t2_mac_pulses", 32'(mv_cnt - mv0), 32'd0);

    // 1 + 2*3 + 0.5*4 = 9.0 with 5 idle operand cycles before each pair
    fma_q.push_back('{d: 32'h4000_0000, w: 32'h4040_0000, a: FP32_ONE,      r: 32'h40E0_0000});
    fma_q.push_back('{d: 32'h3F00_0000, w: 32'h4080_0000, a: 32'h40E0_0000, r: 32'h4110_0000});
    mv0 = mv_cnt;
    do_start(8'd2, FP32_ONE, 17, 32'h4110_0000, 1'b0);
    feed_pair_gap(32'h4000_0000, 32'h4040_0000);
    feed_pair_gap(32'h3F00_0000, 32'h4080_0000);
    wait_for(3, 40, "idle_t3");
    chk("t3_mac_pulses", 32'(mv_cnt - mv0), 32'd2);

    // FMA never answers: 15 WAIT cycles then DONE with err and init value
    fma_en = 1'b0;
    mv0 = mv_cnt;
    do_start(8'd1, FP32_ONE, 17, FP32_ONE, 1'b1);
    feed_pair(32'h4000_0000, 32'h4000_0000);
    op_valid_i = 1'b0;
    wait_for(3, 40, "idle_t4");
    chk("t4_mac_pulses", 32'(mv_cnt - mv0), 32'd1);
    fma_en = 1'b1;

    // result held across res_ready low; start during DONE and on the exit cycle ignored
    fma_q.push_back('{d: FP32_ONE, w: FP32_ONE, a: 32'h4000_0000, r: 32'h4040_0000});
    res_ready_i = 1'b0;
    do_start(8'd1, 32'h4000_0000, 4, 32'h4040_0000, 1'b0);
    feed_pair(FP32_ONE, FP32_ONE);
    op_valid_i = 1'b0;
    wait_for(1, 20, "done_t5");
    @(posedge clk); #1;
    start_i = 1'b1;
    k_i     = 8'd0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    res_ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    chk("t5_idle_busy",      32'(busy_o),      32'h0);
    chk("t5_idle_res_valid", 32'(res_valid_o), 32'h0);
    @(negedge clk);
    chk("t5_idle_busy2",     32'(busy_o),      32'h0);

    // K = 255: counter must reach the full range without wrapping
    for (int i = 0; i < 255; i++)
      fma_q.push_back('{d: FP32_ONE, w: FP32_ZERO, a: 32'(i), r: 32'(i + 1)});
    mv0 = mv_cnt;
    do_start(8'd255, FP32_ZERO, 766, 32'h0000_00FF, 1'b0);
    for (int i = 0; i < 255; i++) feed_pair(FP32_ONE, FP32_ZERO);
    op_valid_i = 1'b0;
    wait_for(3, 40, "idle_t6");
    chk("t6_mac_pulses", 32'(mv_cnt - mv0), 32'd255);

    // reset in WAIT; the late FMA result must be ignored
    fma_delay = 3;
    fma_q.push_back('{d: FP32_ONE, w: FP32_ONE, a: 32'h4000_0000, r: 32'h4040_0000});
    do_start(8'd2, 32'h4000_0000, -1, '0, 1'b0);
    feed_pair(FP32_ONE, FP32_ONE);
    op_valid_i = 1'b0;
    wait_for(2, 10, "mac_valid_t7");
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(negedge clk);
    check_zero("rst_wait");
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t7_late_fma_seen", 32'(mac_finished_i), 32'h1);
    check_zero("late_fma");
    @(negedge clk);
    check_zero("after_late");
    fma_delay = 1;

    chk("sb_empty",  32'(sb.size()),    32'd0);
    chk("fma_empty", 32'(fma_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
